// File: rtl/bcd_chain_ctrl_if.sv
// Command channel for bcd_chain_ctrl: valid/ready handshake carrying an opcode and a BCD preset.
interface bcd_chain_ctrl_if #(
    parameter int unsigned NUM_DIGITS = 4
);
    logic                    cmd_valid;
    logic                    cmd_ready;
    logic [1:0]              cmd_op;
    logic [4*NUM_DIGITS-1:0] cmd_data;

    modport master (output cmd_valid, output cmd_op, output cmd_data, input cmd_ready);
    modport slave  (input cmd_valid, input cmd_op, input cmd_data, output cmd_ready);
endinterface

// File: rtl/bcd_chain_ctrl.sv
// Cascaded decade counter with START/STOP/CLEAR/LOAD command control and sticky wrap/error flags.
// Optional down counting via dir_i when BCD_CHAIN_DOWN_EN is defined.
module bcd_chain_ctrl #(
    parameter int unsigned NUM_DIGITS = 4
) (
    input  logic                    clk,
    input  logic                    clr,
    input  logic                    tick_i,
`ifdef BCD_CHAIN_DOWN_EN
    input  logic                    dir_i,
`endif
    bcd_chain_ctrl_if.slave         cmd,
    output logic [4*NUM_DIGITS-1:0] digits_o,
    output logic [1:0]              state_o,
    output logic                    tc_o,
    output logic                    ovf_o,
    output logic                    err_o
);
    localparam int unsigned W = 4 * NUM_DIGITS;

    localparam logic [1:0] OP_START = 2'b00;
    localparam logic [1:0] OP_STOP  = 2'b01;
    localparam logic [1:0] OP_CLEAR = 2'b10;
    localparam logic [1:0] OP_LOAD  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_RUN   = 2'b01,
        ST_PAUSE = 2'b10,
        ST_LOAD  = 2'b11
    } state_e;

    state_e         state_q, state_d;
    logic [W-1:0]   digits_q, digits_d;
    logic [W-1:0]   preset_q, preset_d;
    logic           tc_q, tc_d;
    logic           ovf_q, ovf_d;
    logic           err_q, err_d;
    logic           ready_q, ready_d;

    logic           down;
    logic [W-1:0]   cnt_nxt;
    logic           cnt_wrap;
    logic           carry;
    logic [3:0]     dig;
    logic           preset_ok;
    logic           xfer;

`ifdef BCD_CHAIN_DOWN_EN
    assign down = dir_i;
`else
    assign down = 1'b0;
`endif

    // Ripple increment/decrement across digits; carry out of the top digit marks a wrap.
    always_comb begin
        carry   = 1'b1;
        dig     = 4'd0;
        cnt_nxt = digits_q;
        for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
            dig = digits_q[4*i +: 4];
            if (carry) begin
                if (down) begin
                    carry = (dig == 4'd0);
                    dig   = (dig == 4'd0) ? 4'd9 : 4'(dig - 4'd1);
                end else begin
                    carry = (dig == 4'd9);
                    dig   = (dig == 4'd9) ? 4'd0 : 4'(dig + 4'd1);
                end
            end
            cnt_nxt[4*i +: 4] = dig;
        end
        cnt_wrap = carry;
    end

    // A preset is usable only if every nibble is a decimal digit.
    always_comb begin
        preset_ok = 1'b1;
        for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
            if (preset_q[4*i +: 4] > 4'd9) begin
                preset_ok = 1'b0;
            end
        end
    end

    assign xfer = cmd.cmd_valid & ready_q;

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_q  <= ST_IDLE;
            digits_q <= '0;
            preset_q <= '0;
            tc_q     <= 1'b0;
            ovf_q    <= 1'b0;
            err_q    <= 1'b0;
            ready_q  <= 1'b1;
        end else begin
            state_q  <= state_d;
            digits_q <= digits_d;
            preset_q <= preset_d;
            tc_q     <= tc_d;
            ovf_q    <= ovf_d;
            err_q    <= err_d;
            ready_q  <= ready_d;
        end
    end

    // Command transfers take priority over ticks; LOAD is a one-cycle commit state.
    always_comb begin
        state_d  = state_q;
        digits_d = digits_q;
        preset_d = preset_q;
        tc_d     = 1'b0;
        ovf_d    = ovf_q;
        err_d    = err_q;

        if (state_q == ST_LOAD) begin
            if (preset_ok) begin
                digits_d = preset_q;
            end else begin
                err_d = 1'b1;
            end
            state_d = ST_IDLE;
        end else if (xfer) begin
            case (cmd.cmd_op)
                OP_START: state_d = ST_RUN;
                OP_STOP: begin
                    if (state_q == ST_RUN) begin
                        state_d = ST_PAUSE;
                    end
                end
                OP_CLEAR: begin
                    digits_d = '0;
                    ovf_d    = 1'b0;
                    err_d    = 1'b0;
                    state_d  = ST_IDLE;
                end
                OP_LOAD: begin
                    preset_d = cmd.cmd_data;
                    state_d  = ST_LOAD;
                end
                default: state_d = state_q;
            endcase
        end else if ((state_q == ST_RUN) && tick_i) begin
            digits_d = cnt_nxt;
            if (cnt_wrap) begin
                ovf_d = 1'b1;
                tc_d  = 1'b1;
            end
        end

        ready_d = (state_d != ST_LOAD);
    end

    assign cmd.cmd_ready = ready_q;
    assign digits_o      = digits_q;
    assign state_o       = state_q;
    assign tc_o          = tc_q;
    assign ovf_o         = ovf_q;
    assign err_o         = err_q;
endmodule

// File: tb/tb_bcd_chain_ctrl.sv
// Scoreboard bench for bcd_chain_ctrl: the driver pushes expected post-edge outputs from a decimal-value model,
// a monitor pops and compares after every rising edge.
module tb_bcd_chain_ctrl;
    localparam int unsigned ND   = 4;
    localparam int unsigned W    = 4 * ND;
    localparam int          MAXV = 10**ND - 1;

    localparam logic [1:0] OP_START = 2'b00;
    localparam logic [1:0] OP_STOP  = 2'b01;
    localparam logic [1:0] OP_CLEAR = 2'b10;
    localparam logic [1:0] OP_LOAD  = 2'b11;

    localparam int S_IDLE = 0, S_RUN = 1, S_PAUSE = 2, S_LOAD = 3;

    typedef struct packed {
        logic [W-1:0] dig;
        logic [1:0]   st;
        logic         tc;
        logic         ovf;
        logic         err;
        logic         rdy;
    } exp_t;

    logic         clk = 1'b0;
    logic         clr = 1'b1;
    logic         tick = 1'b0;
    logic         dir = 1'b0;
    logic [W-1:0] digits;
    logic [1:0]   state;
    logic         tc, ovf, err;

    bcd_chain_ctrl_if #(.NUM_DIGITS(ND)) cif ();

    bcd_chain_ctrl #(.NUM_DIGITS(ND)) dut (
        .clk      (clk),
        .clr      (clr),
        .tick_i   (tick),
`ifdef BCD_CHAIN_DOWN_EN
        .dir_i    (dir),
`endif
        .cmd      (cif),
        .digits_o (digits),
        .state_o  (state),
        .tc_o     (tc),
        .ovf_o    (ovf),
        .err_o    (err)
    );

    initial forever #5 clk = ~clk;

    int   errors = 0;
    int   checks = 0;
    int   pushes = 0;
    int   pops   = 0;
    exp_t sb[$];

    // Reference model: count kept as a plain decimal integer.
    int m_state = S_IDLE;
    int m_val   = 0;
    int m_pre   = 0;
    bit m_pok   = 1'b1;
    bit m_tc    = 1'b0;
    bit m_ovf   = 1'b0;
    bit m_err   = 1'b0;

    function automatic logic [W-1:0] to_bcd(input int v);
        logic [W-1:0] r;
        int           x;
        r = '0;
        x = v;
        for (int i = 0; i < int'(ND); i++) begin
            r[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic exp_t snapshot();
        exp_t e;
        e.dig = to_bcd(m_val);
        e.st  = 2'(m_state);
        e.tc  = m_tc;
        e.ovf = m_ovf;
        e.err = m_err;
        e.rdy = (m_state != S_LOAD);
        return e;
    endfunction

    // One clock of stimulus; model advances to the state after the coming edge.
    task automatic cyc(input logic v, input logic [1:0] op, input logic [W-1:0] d, input logic t, input logic dn);
        bit xfer;
        int nib, acc, mul;
        @(negedge clk);
        cif.cmd_valid = v;
        cif.cmd_op    = op;
        cif.cmd_data  = d;
        tick          = t;
        dir           = dn;
        xfer = v && (m_state != S_LOAD);
        m_tc = 1'b0;
        if (m_state == S_LOAD) begin
            if (m_pok) m_val = m_pre;
            else m_err = 1'b1;
            m_state = S_IDLE;
        end else if (xfer) begin
            case (op)
                OP_START: m_state = S_RUN;
                OP_STOP:  if (m_state == S_RUN) m_state = S_PAUSE;
                OP_CLEAR: begin
                    m_val = 0; m_ovf = 1'b0; m_err = 1'b0; m_state = S_IDLE;
                end
                default: begin
                    m_pok = 1'b1; acc = 0; mul = 1;
                    for (int i = 0; i < int'(ND); i++) begin
                        nib = int'(d[4*i +: 4]);
                        if (nib > 9) m_pok = 1'b0;
                        acc = acc + nib * mul;
                        mul = mul * 10;
                    end
                    m_pre   = acc;
                    m_state = S_LOAD;
                end
            endcase
        end else if (m_state == S_RUN && t) begin
`ifdef BCD_CHAIN_DOWN_EN
            if (dn) begin
                if (m_val == 0) begin m_val = MAXV; m_ovf = 1'b1; m_tc = 1'b1; end
                else m_val = m_val - 1;
            end else
`endif
            begin
                if (m_val == MAXV) begin m_val = 0; m_ovf = 1'b1; m_tc = 1'b1; end
                else m_val = m_val + 1;
            end
        end
        sb.push_back(snapshot());
        pushes++;
    endtask

    task automatic cmd(input logic [1:0] op, input logic [W-1:0] d);
        cyc(1'b1, op, d, 1'b0, 1'b0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, OP_START, '0, 1'b0, 1'b0);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, OP_START, '0, 1'b1, 1'b0);
    endtask

    // Asynchronous reset pulse between edges; outputs checked before any clock edge.
    task automatic rst_pulse();
        @(negedge clk);
        clr           = 1'b0;
        cif.cmd_valid = 1'b0;
        tick          = 1'b0;
        m_state = S_IDLE; m_val = 0; m_pre = 0; m_pok = 1'b1;
        m_tc = 1'b0; m_ovf = 1'b0; m_err = 1'b0;
        #1;
        chk("rst_state",  32'(state),         32'(S_IDLE));
        chk("rst_digits", 32'(digits),        32'(0));
        chk("rst_tc",     32'(tc),            32'(0));
        chk("rst_ovf",    32'(ovf),           32'(0));
        chk("rst_err",    32'(err),           32'(0));
        chk("rst_ready",  32'(cif.cmd_ready), 32'(1));
        @(negedge clk);
        clr = 1'b1;
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #2;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                pops++;
                chk("digits", 32'(digits),        32'(e.dig));
                chk("state",  32'(state),         32'(e.st));
                chk("tc",     32'(tc),            32'(e.tc));
                chk("ovf",    32'(ovf),           32'(e.ovf));
                chk("err",    32'(err),           32'(e.err));
                chk("ready",  32'(cif.cmd_ready), 32'(e.rdy));
            end
        end
    end

    initial begin : driver
        logic [W-1:0] d;
        logic [1:0]   op;
        cif.cmd_valid = 1'b0;
        cif.cmd_op    = OP_START;
        cif.cmd_data  = '0;
        rst_pulse();

        // Ten ticks from zero carry into the tens digit
        cmd(OP_START, '0);
        ticks(10);
        idle(2);

        // Wrap from 9998 after two ticks
        cmd(OP_CLEAR, '0);
        cmd(OP_LOAD, 16'h9998);
        idle(1);
        cmd(OP_START, '0);
        ticks(2);
        idle(3);

        // Invalid preset sets err and keeps count; CLEAR resets flags
        cmd(OP_LOAD, 16'h0042);
        idle(1);
        cmd(OP_LOAD, 16'h12A4);
        idle(2);
        cmd(OP_CLEAR, '0);
        idle(1);

        // STOP together with a tick suppresses the count; PAUSE ignores ticks
        cmd(OP_START, '0);
        ticks(3);
        cyc(1'b1, OP_STOP, '0, 1'b1, 1'b0);
        ticks(5);
        cyc(1'b1, OP_START, '0, 1'b1, 1'b0);
        ticks(2);

        // Back-to-back wraps each give a pulse
        for (int k = 0; k < 2; k++) begin
            cmd(OP_LOAD, 16'h9999);
            idle(1);
            cmd(OP_START, '0);
            ticks(1);
        end
        ticks(2);

        // Reset during LOAD discards the preset
        cmd(OP_LOAD, 16'h0042);
        idle(1);
        cmd(OP_LOAD, 16'h5555);
        rst_pulse();
        idle(2);

`ifdef BCD_CHAIN_DOWN_EN
        cmd(OP_CLEAR, '0);
        cmd(OP_START, '0);
        cyc(1'b0, OP_START, '0, 1'b1, 1'b1);
        cyc(1'b0, OP_START, '0, 1'b1, 1'b1);
        idle(1);
`endif

        // Randomized traffic biased towards near-wrap presets
        for (int n = 0; n < 2500; n++) begin
            op = 2'($urandom_range(3, 0));
            case ($urandom_range(2, 0))
                0:       d = W'($urandom);
                1:       d = to_bcd(MAXV - int'($urandom_range(9, 0)));
                default: d = to_bcd(int'($urandom_range(MAXV, 0)));
            endcase
            if (op == OP_CLEAR && $urandom_range(3, 0) != 0) op = OP_START;
            cyc(($urandom_range(4, 0) == 0), op, d, ($urandom_range(3, 0) != 0),
                1'($urandom_range(1, 0)));
            if ($urandom_range(499, 0) == 0) rst_pulse();
        end

        idle(1);
        @(negedge clk);
        @(negedge clk);
        chk("sb_drain", 32'(sb.size()), 32'(0));
        chk("sb_count", 32'(pops),      32'(pushes));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/bcd_chain_ctrl.md
BCD_CHAIN_CTRL -- requirements
Module: bcd_chain_ctrl

Interface
REQ-001 The block SHALL have parameter NUM_DIGITS, default 4, giving the number of cascaded decade digits (legal range 1..8).
REQ-002 The block SHALL have port clk, input, 1 bit: rising-edge clock for all state.
REQ-003 The block SHALL have port clr, input, 1 bit: reset, asynchronous, active-low.
REQ-004 The block SHALL have port tick_i, input, 1 bit: count event, sampled each clk edge.
REQ-005 The block SHALL have port cmd_valid, input, 1 bit: command request.
REQ-006 The block SHALL have port cmd_ready, output, 1 bit: command accept; a transfer occurs when cmd_valid and cmd_ready are both 1.
REQ-007 The block SHALL have port cmd_op, input, 2 bits: 00 START, 01 STOP, 10 CLEAR, 11 LOAD.
REQ-008 The block SHALL have port cmd_data, input, 4*NUM_DIGITS bits: BCD preset for LOAD; digit 0 is in bits [3:0].
REQ-009 The block SHALL have port digits_o, output, 4*NUM_DIGITS bits: current BCD count.
REQ-010 The block SHALL have port state_o, output, 2 bits: 00 IDLE, 01 RUN, 10 PAUSE, 11 LOAD.
REQ-011 The block SHALL have port tc_o, output, 1 bit: registered one-cycle terminal-count pulse.
REQ-012 The block SHALL have port ovf_o, output, 1 bit: sticky wrap flag.
REQ-013 The block SHALL have port err_o, output, 1 bit: sticky invalid-preset flag.

Function
REQ-014 In IDLE, a START transfer SHALL move to RUN, STOP SHALL have no effect, CLEAR SHALL zero the count, and LOAD SHALL move to LOAD.
REQ-015 In RUN, STOP SHALL move to PAUSE, CLEAR SHALL zero the count and move to IDLE, LOAD SHALL move to LOAD, and START SHALL have no effect.
REQ-016 In PAUSE, START SHALL return to RUN, CLEAR SHALL zero the count and move to IDLE, LOAD SHALL move to LOAD, and STOP SHALL have no effect.
REQ-017 LOAD SHALL last exactly one cycle with cmd_ready=0 and SHALL then return to IDLE.
REQ-018 In LOAD, the preset captured at the LOAD transfer SHALL be written to digits_o only if every digit is <=9.
REQ-019 If any preset digit is >9, LOAD SHALL leave the count unchanged and SHALL set err_o.
REQ-020 cmd_ready SHALL be 1 in IDLE, RUN and PAUSE.
REQ-021 A count SHALL occur only when the state is RUN, tick_i=1, and no command transfer occurs in that cycle; a command transfer SHALL suppress that cycle's tick.
REQ-022 On a count, digit 0 SHALL increment; a digit at 9 SHALL become 0 and carry into the next digit. digits_o SHALL update on the same edge (one-cycle latency).
REQ-023 A count from all-9s SHALL wrap to all-0s, SHALL set ovf_o, and SHALL assert tc_o for exactly the following cycle.
REQ-024 Back-to-back wraps SHALL produce one tc_o pulse per wrap.
REQ-025 CLEAR SHALL also reset ovf_o and err_o to 0.
REQ-026 digits_o SHALL never hold a non-BCD digit.

Reset
REQ-027 While clr=0, the block SHALL set state IDLE, digits_o=0, tc_o=0, ovf_o=0, err_o=0, cmd_ready=1, asynchronously.
REQ-028 Reset asserted mid-operation, including during LOAD, SHALL abort the operation and discard any pending preset.
REQ-029 After clr is released, the first transfer or count SHALL take effect on the next rising clk edge.

Configuration
REQ-030 With macro BCD_CHAIN_DOWN_EN defined, the block SHALL add input dir_i (1 bit, 1 = down).
REQ-031 When dir_i=1, a count SHALL decrement with a borrow chain (digit 0 becomes 9 and borrows); a count from all-0s SHALL wrap to all-9s, set ovf_o and pulse tc_o.
REQ-032 Without BCD_CHAIN_DOWN_EN, dir_i SHALL not exist and counting SHALL be up-only.

Verification
REQ-033 Reset, START, then 10 ticks SHALL give digits_o=0x0010 and tc_o never asserted.
REQ-034 LOAD 0x9998, START, then 2 ticks SHALL give digits_o=0x0000, ovf_o=1, and tc_o=1 for exactly one cycle.
REQ-035 LOAD 0x12A4 SHALL give err_o=1 and leave digits_o unchanged; a following CLEAR SHALL give err_o=0 and digits_o=0.
REQ-036 In RUN, STOP issued in the same cycle as tick_i=1 SHALL leave the count unchanged; 5 further ticks in PAUSE SHALL leave it unchanged.
REQ-037 Pulsing clr low during LOAD of 0x5555 SHALL leave digits_o=0 and state_o=IDLE.
REQ-038 With BCD_CHAIN_DOWN_EN, dir_i=1, count 0x0000, START and 1 tick SHALL give digits_o=0x9999 and ovf_o=1.
